uart_text_writer: RTL and testbench
===================================

# uart_text_writer

Serial-to-text-buffer front end for the VGA character display. Receives 8N1 UART bytes and interprets them as ASCII text and control codes. Keeps a cursor and emits single-cycle write strobes into the 40×15 character buffer that the character generator reads. It is the writer for that buffer; the display path is the reader.

## Interface
Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200).
- COLS, 40, character columns per row.
- ROWS, 15, character rows.

Ports:
- clk  in  1  system clock; the block's only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- i_uart_rx  in  1  serial input, idle high, asynchronous to clk.
- o_wr_en  out  1  one-cycle write strobe to the character buffer.
- o_wr_addr  out  10  cell address, row*COLS+col.
- o_wr_data  out  8  ASCII code to store.
- o_cursor_col  out  6  current cursor column.
- o_cursor_row  out  4  current cursor row.
- o_rx_err  out  1  one-cycle pulse on framing error.
- o_busy  out  1  high while a multi-cycle operation (clear) runs.

## Operation
- Input path: i_uart_rx passes through a 2-flop synchronizer; all later logic uses the synchronized copy.
- RX FSM states are IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized falling edge.
  - START checks the line at CLKS_PER_BIT/2. Low: go to DATA. High: glitch, back to IDLE with no error.
  - DATA samples 8 bits LSB first, each CLKS_PER_BIT after the previous sample.
  - STOP samples the stop bit. High: byte accepted. Low: o_rx_err pulses, the byte is discarded, FSM returns to IDLE.
- Byte handling, one accepted byte at a time:
  - 0x20–0x7E: write the byte at the cursor, then advance col.
  - 0x0D (CR): col=0, row=row+1. No write.
  - 0x08 (BS): if col>0, col=col-1 and write 0x20 at the new cell. At col 0, no action.
  - All other codes: ignored, no write.
- Wrap rules:
  - Advancing from col COLS-1 gives col 0, row+1.
  - row+1 from row ROWS-1 gives row 0 (wrap to top, no scrolling).
  - BS never moves to the previous row.
- Address: o_wr_addr = row*COLS+col, computed in 10 bits; the maximum is 599.
- Reset values: o_wr_en=0, o_wr_addr=0, o_wr_data=0, cursor (0,0), o_rx_err=0, o_busy=0, RX FSM in IDLE.
- Reset mid-frame abandons the frame, and no write is issued.

## Timing
- Accepted byte: o_wr_en is high exactly one cycle, on the cycle after the stop-bit sample. o_wr_addr and o_wr_data are valid in that same cycle.
- The cursor outputs update on the same edge as o_wr_en goes high, i.e. they already show the post-advance position.
- The write uses the pre-advance address.
- From the synchronized start edge to o_wr_en: CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles.
- o_rx_err is high one cycle, on the cycle after the failing stop sample.
- No back-pressure: the buffer must accept a write on every o_wr_en.
- The RX FSM may begin the next frame in the cycle after the stop sample.

## Configuration
- CLEAR_SCREEN_EN defined:
  - Byte 0x0C (FF) enters a CLEAR state and asserts o_busy.
  - CLEAR writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle, with o_wr_en high for COLS*ROWS consecutive cycles.
  - On completion the cursor is (0,0) and o_busy drops on the cycle after the last write.
  - A byte accepted during CLEAR is held in a one-entry pending register and processed after CLEAR finishes. With the defaults a clear (600 cycles) always ends before the next byte (≥8680 cycles).
- CLEAR_SCREEN_EN undefined: 0x0C is ignored, o_busy is tied 0, and there is no CLEAR state or pending register.

## Structure
- Shared package uart_text_pkg holds:
  - RX state enum.
  - ASCII constants CHAR_CR, CHAR_BS, CHAR_FF, CHAR_SPACE.
  - Default COLS/ROWS.
- The character generator imports the same COLS/ROWS.
- One natural sub-module: uart_rx_core (synchronizer, RX FSM, bit counter, baud counter), outputting byte, valid and framing error.
- Cursor and text logic stay in the top.

## Test plan
- Reset, then send 0x41 at CLKS_PER_BIT=8 -> one o_wr_en with addr 0, data 0x41; cursor becomes (1,0).
- Cursor at (39,14), send 0x5A -> write to addr 599, data 0x5A; cursor becomes (0,0).
- Send 0x41, 0x08, 0x08 -> writes 0x41@0, then 0x20@0; cursor (0,0); the second BS produces no write.
- Cursor at (7,3), send 0x0D -> no write; cursor becomes (0,4). Send 0x07 -> no write, cursor unchanged.
- Frame with stop bit 0 -> o_rx_err pulses once, no o_wr_en, cursor unchanged. A following valid 0x31 is written normally.
- With CLEAR_SCREEN_EN, send 0x0C at cursor (5,2) -> 600 consecutive writes of 0x20 at addr 0..599, o_busy high throughout, cursor ends at (0,0). Asserting rst_n low midway -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/uart_text_pkg.sv
// Shared types and constants for the UART text writer and the character display path.
// Optional clear-screen support is enabled with the CLEAR_SCREEN_EN macro.
package uart_text_pkg;

  localparam int DEFAULT_COLS = 40;
  localparam int DEFAULT_ROWS = 15;

  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

`ifdef CLEAR_SCREEN_EN
  typedef enum logic {
    TW_RUN,
    TW_CLEAR
  } text_state_e;
`endif

  // Linear cell address; callers guarantee row < ROWS and col < cols.
  function automatic logic [9:0] cell_addr(input logic [3:0] row, input logic [5:0] col,
                                           input int cols);
    return 10'(row) * 10'(cols) + 10'(col);
  endfunction

endpackage

// File: rtl/uart_text_writer_if.sv
// Write port into the character buffer, plus the RX FSM state for observation.
// wr_en is a valid-only strobe: there is no ready, the sink must take every write.
interface uart_text_writer_if;
  import uart_text_pkg::*;

  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  rx_state_e  rx_state;

  modport master (output wr_en, wr_addr, wr_data, rx_state);
  modport slave  (input  wr_en, wr_addr, wr_data, rx_state);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM.
// rx_valid / rx_frame_err are combinational pulses in the stop-sample cycle.
module uart_rx_core
  import uart_text_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output rx_state_e  rx_state
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta, rx_sync, rx_prev;
  rx_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       shreg, shreg_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_nxt      = bit_idx;
    shreg_nxt    = shreg;
    rx_valid     = 1'b0;
    rx_frame_err = 1'b0;
    unique case (state)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (rx_prev && !rx_sync) state_nxt = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          // A line that is high again at mid-start was a glitch, not a frame.
          state_nxt = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_sync, shreg[7:1]};
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = RX_STOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt      = '0;
          state_nxt    = RX_IDLE;
          rx_valid     = rx_sync;
          rx_frame_err = !rx_sync;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  assign rx_byte  = shreg;
  assign rx_state = state;

endmodule

// File: rtl/uart_text_writer.sv
// UART-to-character-buffer writer: cursor tracking, printable/CR/BS handling.
// Define CLEAR_SCREEN_EN to add form-feed screen clear with a one-byte pending slot.
module uart_text_writer
  import uart_text_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int COLS         = DEFAULT_COLS,
  parameter int ROWS         = DEFAULT_ROWS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_uart_rx,
  uart_text_writer_if.master wr_bus,
  output logic [5:0]         o_cursor_col,
  output logic [3:0]         o_cursor_row,
  output logic               o_rx_err,
  output logic               o_busy
);

  localparam logic [5:0] COL_LAST = 6'(COLS - 1);
  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_frame_err;
  rx_state_e  rx_state;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (i_uart_rx),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_state     (rx_state)
  );

  logic       wr_en_q, wr_en_nxt;
  logic [9:0] wr_addr_q, wr_addr_nxt;
  logic [7:0] wr_data_q, wr_data_nxt;
  logic [5:0] col_q, col_nxt;
  logic [3:0] row_q, row_nxt;
  logic       err_q;
  logic [7:0] cur_byte;
  logic       cur_valid;

  function automatic logic [3:0] row_inc(input logic [3:0] r);
    return (r == ROW_LAST) ? 4'd0 : r + 4'd1;
  endfunction

`ifdef CLEAR_SCREEN_EN
  localparam logic [9:0] CELL_LAST = 10'(COLS * ROWS - 1);
  text_state_e state_q, state_nxt;
  logic [9:0]  clr_q, clr_nxt;
  logic        pend_valid_q, pend_valid_nxt;
  logic [7:0]  pend_byte_q, pend_byte_nxt;
  logic        busy_q;
`endif

  always_comb begin
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr_q;
    wr_data_nxt = wr_data_q;
    col_nxt     = col_q;
    row_nxt     = row_q;
    cur_byte    = rx_byte;
    cur_valid   = rx_valid;
`ifdef CLEAR_SCREEN_EN
    state_nxt      = state_q;
    clr_nxt        = clr_q;
    pend_valid_nxt = pend_valid_q;
    pend_byte_nxt  = pend_byte_q;
    if (state_q == TW_CLEAR) begin
      cur_valid   = 1'b0;
      if (rx_valid) begin
        pend_valid_nxt = 1'b1;
        pend_byte_nxt  = rx_byte;
      end
      wr_en_nxt   = 1'b1;
      wr_addr_nxt = clr_q;
      wr_data_nxt = CHAR_SPACE;
      clr_nxt     = clr_q + 10'd1;
      if (clr_q == CELL_LAST) begin
        state_nxt = TW_RUN;
        clr_nxt   = '0;
        col_nxt   = '0;
        row_nxt   = '0;
      end
    end else if (pend_valid_q) begin
      // Drain the held byte first; a byte arriving now takes its slot.
      cur_byte       = pend_byte_q;
      cur_valid      = 1'b1;
      pend_valid_nxt = rx_valid;
      pend_byte_nxt  = rx_byte;
    end
`endif
    if (cur_valid) begin
      if (cur_byte >= 8'h20 && cur_byte <= 8'h7E) begin
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = cell_addr(row_q, col_q, COLS);
        wr_data_nxt = cur_byte;
        if (col_q == COL_LAST) begin
          col_nxt = '0;
          row_nxt = row_inc(row_q);
        end else begin
          col_nxt = col_q + 6'd1;
        end
      end else if (cur_byte == CHAR_CR) begin
        col_nxt = '0;
        row_nxt = row_inc(row_q);
      end else if (cur_byte == CHAR_BS) begin
        if (col_q != 6'd0) begin
          col_nxt     = col_q - 6'd1;
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = cell_addr(row_q, col_q - 6'd1, COLS);
          wr_data_nxt = CHAR_SPACE;
        end
      end
`ifdef CLEAR_SCREEN_EN
      else if (cur_byte == CHAR_FF) begin
        // Cell 0 is written on entry, so CLEAR itself starts at cell 1.
        state_nxt   = TW_CLEAR;
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = '0;
        wr_data_nxt = CHAR_SPACE;
        clr_nxt     = 10'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_nxt;
      wr_addr_q <= wr_addr_nxt;
      wr_data_q <= wr_data_nxt;
      col_q     <= col_nxt;
      row_q     <= row_nxt;
      err_q     <= rx_frame_err;
    end
  end

`ifdef CLEAR_SCREEN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TW_RUN;
      clr_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_byte_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      clr_q        <= clr_nxt;
      pend_valid_q <= pend_valid_nxt;
      pend_byte_q  <= pend_byte_nxt;
      // Stays high one cycle past the final state so it covers the last write.
      busy_q       <= (state_nxt == TW_CLEAR) || (state_q == TW_CLEAR);
    end
  end
  assign o_busy = busy_q;
`else
  assign o_busy = 1'b0;
`endif

  assign wr_bus.wr_en    = wr_en_q;
  assign wr_bus.wr_addr  = wr_addr_q;
  assign wr_bus.wr_data  = wr_data_q;
  assign wr_bus.rx_state = rx_state;
  assign o_cursor_col    = col_q;
  assign o_cursor_row    = row_q;
  assign o_rx_err        = err_q;

endmodule

// File: tb/tb_uart_text_writer.sv
// Directed bench for uart_text_writer at CLKS_PER_BIT=8; clear-screen cases run
// only when CLEAR_SCREEN_EN is defined.
module tb_uart_text_writer;
  import uart_text_pkg::*;

  localparam int CPB = 8;
  // Synchronizer adds two cycles in front of the start-edge-to-write latency.
  localparam int LAT = CPB / 2 + 9 * CPB + 1 + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [5:0] cur_col;
  logic [3:0] cur_row;
  logic       rx_err;
  logic       busy;

  uart_text_writer_if wr_bus ();

  uart_text_writer #(.CLKS_PER_BIT(CPB), .COLS(40), .ROWS(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_uart_rx    (rx),
    .wr_bus       (wr_bus),
    .o_cursor_col (cur_col),
    .o_cursor_row (cur_row),
    .o_rx_err     (rx_err),
    .o_busy       (busy)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [17:0] exp_q[$];
  logic [17:0] e;
  int n_checks = 0;
  int n_errors = 0;
  int unexp_cnt = 0;
  int err_pulses = 0;
  int run_len = 0;
  int max_run = 0;
  int wr_busy = 0;
  int busy_cyc = 0;
  int last_wr_cyc = 0;
  int drive_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_bus.wr_en) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      last_wr_cyc = cyc;
      if (busy) wr_busy++;
      if (exp_q.size() == 0) begin
        unexp_cnt++;
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_bus.wr_addr), 32'(e[17:8]));
        check("wr_data", 32'(wr_bus.wr_data), 32'(e[7:0]));
      end
    end else begin
      run_len = 0;
    end
    if (busy) busy_cyc++;
    if (rx_err) err_pulses++;
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    drive_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_exp(input logic [7:0] b, input logic [9:0] addr);
    exp_q.push_back({addr, b});
    send_byte(b, 1'b1);
  endtask

  task automatic expect_cursor(input string tag, input logic [5:0] col, input logic [3:0] row);
    check({tag, "_col"}, 32'(cur_col), 32'(col));
    check({tag, "_row"}, 32'(cur_row), 32'(row));
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, "_pending_wr"}, exp_q.size(), 0);
    check({tag, "_unexpected_wr"}, unexp_cnt, 0);
  endtask

  task automatic expect_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 32'(wr_bus.wr_en), 0);
    check({tag, "_wr_addr"}, 32'(wr_bus.wr_addr), 0);
    check({tag, "_wr_data"}, 32'(wr_bus.wr_data), 0);
    check({tag, "_rx_err"}, 32'(rx_err), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rx_state"}, 32'(wr_bus.rx_state), 32'(RX_IDLE));
    expect_cursor(tag, 6'd0, 4'd0);
  endtask

  initial begin
    int e0;
    int t;

    // reset
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    expect_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // single printable byte plus latency
    send_exp(8'h41, 10'd0);
    check("latency", last_wr_cyc - drive_cyc, LAT);
    expect_cursor("after_41", 6'd1, 4'd0);
    expect_quiet("after_41");

    // backspace, then backspace at column 0
    exp_q.push_back({10'd0, 8'h20});
    send_byte(CHAR_BS, 1'b1);
    expect_cursor("bs1", 6'd0, 4'd0);
    send_byte(CHAR_BS, 1'b1);
    expect_cursor("bs2", 6'd0, 4'd0);
    expect_quiet("bs");

    // move to (7,3), then CR and an ignored control code
    repeat (3) send_byte(CHAR_CR, 1'b1);
    for (int c = 0; c < 7; c++) send_exp(8'h61 + 8'(c), 10'(120 + c));
    expect_cursor("pos_7_3", 6'd7, 4'd3);
    send_byte(CHAR_CR, 1'b1);
    expect_cursor("cr", 6'd0, 4'd4);
    send_byte(8'h07, 1'b1);
    expect_cursor("bel", 6'd0, 4'd4);
    expect_quiet("cr_bel");

    // framing error, then a normal byte
    e0 = err_pulses;
    send_byte(8'h55, 1'b0);
    check("frame_err_pulses", err_pulses - e0, 1);
    expect_cursor("frame_err", 6'd0, 4'd4);
    expect_quiet("frame_err");
    send_exp(8'h31, 10'd160);
    expect_cursor("after_31", 6'd1, 4'd4);

    // short start glitch is ignored
    e0 = err_pulses;
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_rx_state", 32'(wr_bus.rx_state), 32'(RX_IDLE));
    check("glitch_err", err_pulses - e0, 0);
    expect_cursor("glitch", 6'd1, 4'd4);
    expect_quiet("glitch");

    // column wrap within the screen, then row wrap at the bottom-right cell
    for (int c = 1; c < 39; c++) send_exp(8'h30 + 8'(c), 10'(160 + c));
    expect_cursor("pos_39_4", 6'd39, 4'd4);
    send_exp(8'h7E, 10'd199);
    expect_cursor("col_wrap", 6'd0, 4'd5);
    repeat (9) send_byte(CHAR_CR, 1'b1);
    expect_cursor("pos_0_14", 6'd0, 4'd14);
    for (int c = 0; c < 39; c++) send_exp(8'h30 + 8'(c), 10'(560 + c));
    expect_cursor("pos_39_14", 6'd39, 4'd14);
    send_exp(8'h5A, 10'd599);
    expect_cursor("row_wrap", 6'd0, 4'd0);
    expect_quiet("wrap");

    // reset in the middle of a frame
    send_exp(8'h43, 10'd0);
    expect_cursor("before_mid_rst", 6'd1, 4'd0);
    @(negedge clk);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_reset_outputs("mid_frame_rst");
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    expect_quiet("mid_frame_rst");
    send_exp(8'h42, 10'd0);
    expect_cursor("after_mid_rst", 6'd1, 4'd0);

`ifdef CLEAR_SCREEN_EN
    // clear screen from (5,2)
    repeat (2) send_byte(CHAR_CR, 1'b1);
    for (int c = 0; c < 5; c++) send_exp(8'h41 + 8'(c), 10'(80 + c));
    expect_cursor("pos_5_2", 6'd5, 4'd2);
    max_run  = 0;
    wr_busy  = 0;
    busy_cyc = 0;
    for (int a = 0; a < 600; a++) exp_q.push_back({10'(a), 8'h20});
    send_byte(CHAR_FF, 1'b1);
    t = 0;
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("clear_done_in_time", 32'(t < 2000), 1);
    repeat (2) @(negedge clk);
    check("clear_run_len", max_run, 600);
    check("clear_wr_with_busy", wr_busy, 600);
    check("clear_busy_cycles", busy_cyc, 600);
    expect_cursor("after_clear", 6'd0, 4'd0);
    expect_quiet("clear");

    // reset while a clear is in progress
    send_exp(8'h44, 10'd0);
    for (int a = 0; a < 600; a++) exp_q.push_back({10'(a), 8'h20});
    send_byte(CHAR_FF, 1'b1);
    repeat (100) @(negedge clk);
    check("busy_before_rst", 32'(busy), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    expect_reset_outputs("clear_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_exp(8'h45, 10'd0);
    expect_cursor("after_clear_rst", 6'd1, 4'd0);
    expect_quiet("clear_rst");
`else
    // form feed is an ignored code in this build
    busy_cyc = 0;
    send_byte(CHAR_FF, 1'b1);
    check("ff_busy_cycles", busy_cyc, 0);
    expect_cursor("ff_ignored", 6'd1, 4'd0);
    expect_quiet("ff_ignored");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
